// File: rtl/npxl_pkg.sv
// Shared types and constants for the WS2812 VU-meter driver: FSM states,
// GRB colour encoding and default WS2812 timing at the reference clock.
package npxl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_LATCH
  } state_t;

  typedef enum logic [2:0] {
    CLR_OFF,
    CLR_GREEN,
    CLR_YELLOW,
    CLR_RED,
    CLR_WHITE
  } colour_t;

  localparam int DEF_LEDS    = 20;
  localparam int DEF_T0H_CYC = 20;
  localparam int DEF_T1H_CYC = 40;
  localparam int DEF_BIT_CYC = 63;
  localparam int DEF_RST_CYC = 3000;
  localparam logic [7:0]  DEF_BRIGHT = 8'h20;
  localparam logic [23:0] GRB_OFF    = 24'h000000;

  // WS2812 expects green first, then red, then blue.
  function automatic logic [23:0] grb_word(colour_t c, logic [7:0] br);
    case (c)
      CLR_GREEN:  return {br, 8'h00, 8'h00};
      CLR_YELLOW: return {br, br, 8'h00};
      CLR_RED:    return {8'h00, br, 8'h00};
      CLR_WHITE:  return {br, br, br};
      default:    return GRB_OFF;
    endcase
  endfunction

endpackage

// File: rtl/npxl_vu_driver_if.sv
// Frame request / serial output bundle of the VU-meter driver.
interface npxl_vu_driver_if #(
  parameter int ADDR = 8
);
  logic            i_send;
  logic [ADDR-1:0] i_value;
  logic            o_npxl_data;
  logic            o_rdy;

  modport master (output i_send, output i_value, input o_npxl_data, input o_rdy);
  modport slave  (input i_send, input i_value, output o_npxl_data, output o_rdy);
endinterface

// File: rtl/npxl_bit_tx.sv
// Serialises one 24-bit GRB word MSB first with WS2812 high/low bit timing;
// o_done marks the final clock of the last bit.
module npxl_bit_tx #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [23:0] i_word,
  output logic        o_data,
  output logic        o_hi_end,
  output logic        o_bit_end,
  output logic        o_done
);
  localparam int CW = $clog2(BIT_CYC + 1);

  logic          busy_q, busy_d;
  logic [23:0]   word_q, word_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_len;

  // The bit in flight is always word_q[23]; the word shifts left per bit.
  assign hi_len    = word_q[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign o_data    = busy_q && (cnt_q < hi_len);
  assign o_hi_end  = busy_q && (cnt_q == hi_len - 1'b1);
  assign o_bit_end = busy_q && (cnt_q == CW'(BIT_CYC - 1));
  assign o_done    = o_bit_end && (bit_q == 5'd0);

  always_comb begin
    busy_d = busy_q;
    word_d = word_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    if (i_start) begin
      busy_d = 1'b1;
      word_d = i_word;
      bit_d  = 5'd23;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (o_bit_end) begin
        cnt_d  = '0;
        word_d = {word_q[22:0], 1'b0};
        if (bit_q == 5'd0) busy_d = 1'b0;
        else               bit_d  = bit_q - 5'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      word_q <= '0;
      bit_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      word_q <= word_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/npxl_vu_driver.sv
// WS2812 bar-graph driver: green/yellow/red bar of i_value pixels per frame.
// Optional peak-hold marker (white pixel) enabled by macro NPXL_PEAK_HOLD_EN.
module npxl_vu_driver
  import npxl_pkg::*;
#(
  parameter int         LEDS       = DEF_LEDS,
  parameter int         ADDR       = 8,
  parameter int         T0H_CYC    = DEF_T0H_CYC,
  parameter int         T1H_CYC    = DEF_T1H_CYC,
  parameter int         BIT_CYC    = DEF_BIT_CYC,
  parameter int         RST_CYC    = DEF_RST_CYC,
  parameter int         YEL_START  = 12,
  parameter int         RED_START  = 16,
  parameter logic [7:0] BRIGHT     = DEF_BRIGHT,
  parameter int         PEAK_DECAY = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  npxl_vu_driver_if.slave  bus
);
  localparam int LW = $clog2(RST_CYC + 1);

  if ((LEDS < 1) || (LEDS > 255) || (PEAK_DECAY < 1)) begin : g_bad_param
    $error("npxl_vu_driver: LEDS must be 1..255 and PEAK_DECAY >= 1");
  end

  state_t          state_q, state_d;
  logic [ADDR-1:0] led_q, led_d;
  logic [ADDR-1:0] v_q, v_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [ADDR-1:0] v_new;
  logic            accept, last_led, peak_white;
  logic            tx_start, tx_data, tx_hi_end, tx_bit_end, tx_done;
  colour_t         colour;
  logic [23:0]     word;

  assign v_new    = (bus.i_value > ADDR'(LEDS)) ? ADDR'(LEDS) : bus.i_value;
  assign accept   = (state_q == ST_IDLE) && bus.i_send;
  assign last_led = (led_q == ADDR'(LEDS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.i_send) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_BIT_HI;
      ST_BIT_HI: if (tx_hi_end) state_d = ST_BIT_LO;
      ST_BIT_LO: begin
        if (tx_done)         state_d = last_led ? ST_LATCH : ST_LOAD;
        else if (tx_bit_end) state_d = ST_BIT_HI;
      end
      ST_LATCH:  if (lat_q == LW'(RST_CYC - 1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_rdy       = (state_q == ST_IDLE);
    bus.o_npxl_data = tx_data;
    tx_start        = (state_q == ST_LOAD);
  end

  always_comb begin
    v_d   = v_q;
    led_d = led_q;
    lat_d = lat_q;
    if (accept) begin
      v_d   = v_new;
      led_d = '0;
      lat_d = '0;
    end else if ((state_q == ST_BIT_LO) && tx_done && !last_led) begin
      led_d = led_q + 1'b1;
    end else if (state_q == ST_LATCH) begin
      lat_d = lat_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q   <= '0;
      led_q <= '0;
      lat_q <= '0;
    end else begin
      v_q   <= v_d;
      led_q <= led_d;
      lat_q <= lat_d;
    end
  end

`ifdef NPXL_PEAK_HOLD_EN
  localparam int FW = $clog2(PEAK_DECAY + 1);
  logic [ADDR-1:0] peak_q, peak_d;
  logic [FW-1:0]   fc_q, fc_d;

  // A new maximum restarts the decay interval; otherwise every PEAK_DECAY
  // accepted frames the marker drops by one pixel.
  always_comb begin
    peak_d = peak_q;
    fc_d   = fc_q;
    if (accept) begin
      if (v_new > peak_q) begin
        peak_d = v_new;
        fc_d   = '0;
      end else if (fc_q == FW'(PEAK_DECAY - 1)) begin
        fc_d = '0;
        if (peak_q != '0) peak_d = peak_q - 1'b1;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      peak_q <= '0;
      fc_q   <= '0;
    end else begin
      peak_q <= peak_d;
      fc_q   <= fc_d;
    end
  end

  assign peak_white = (peak_q > v_q) && (led_q == peak_q - 1'b1);
`else
  assign peak_white = 1'b0;
`endif

  always_comb begin
    colour = CLR_OFF;
    if (led_q < v_q) begin
      if (led_q < ADDR'(YEL_START))      colour = CLR_GREEN;
      else if (led_q < ADDR'(RED_START)) colour = CLR_YELLOW;
      else                               colour = CLR_RED;
    end else if (peak_white) begin
      colour = CLR_WHITE;
    end
  end

  assign word = grb_word(colour, BRIGHT);

  npxl_bit_tx #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_tx (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (tx_start),
    .i_word    (word),
    .o_data    (tx_data),
    .o_hi_end  (tx_hi_end),
    .o_bit_end (tx_bit_end),
    .o_done    (tx_done)
  );
endmodule

// File: tb/tb_npxl_vu_driver.sv
// Self-checking bench: decodes the serial line into pixel words and compares
// them, the bit timing and the frame length against a behavioural model.
module tb_npxl_vu_driver;
  localparam int         LEDS       = 20;
  localparam int         ADDR       = 8;
  localparam int         T0H        = 2;
  localparam int         T1H        = 5;
  localparam int         BITC       = 8;
  localparam int         RSTC       = 30;
  localparam int         YEL        = 12;
  localparam int         RED        = 16;
  localparam logic [7:0] BR         = 8'h20;
  localparam int         DECAY      = 8;
  localparam int         FRAME_LEN  = 1 + LEDS * (1 + 24 * BITC) + RSTC;
`ifdef NPXL_PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_peak = 0;
  int   m_fc = 0;

  npxl_vu_driver_if #(.ADDR(ADDR)) bus ();

  npxl_vu_driver #(
    .LEDS(LEDS), .ADDR(ADDR), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC),
    .RST_CYC(RSTC), .YEL_START(YEL), .RED_START(RED), .BRIGHT(BR),
    .PEAK_DECAY(DECAY)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] exp_word(int k, int v, int pk);
    if (k < v) begin
      if (k < YEL)      return {BR, 8'h00, 8'h00};
      else if (k < RED) return {BR, BR, 8'h00};
      else              return {8'h00, BR, 8'h00};
    end
    if (pk > v && k == pk - 1) return {BR, BR, BR};
    return 24'h0;
  endfunction

  task automatic model_accept(input int val, output int v);
    v = (val > LEDS) ? LEDS : val;
    if (PK) begin
      if (v > m_peak) begin
        m_peak = v;
        m_fc = 0;
      end else begin
        m_fc++;
        if (m_fc == DECAY) begin
          m_fc = 0;
          if (m_peak > 0) m_peak--;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_send = 1'b0;
    bus.i_value = '0;
    m_peak = 0;
    m_fc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", bus.o_rdy, 1);
    chk("rst_data", bus.o_npxl_data, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_rdy", bus.o_rdy, 1);
    chk("post_rst_data", bus.o_npxl_data, 0);
  endtask

  task automatic run_frame(input int val, input bit hold, input string tag);
    int v;
    int busy = 0, hi_run = 0, lo_run = 0, nbits = 0, bad_hi = 0, last_hi = 0;
    logic [23:0] words [LEDS];
    for (int k = 0; k < LEDS; k++) words[k] = '0;
    chk({tag, "_rdy_pre"}, bus.o_rdy, 1);
    bus.i_value = ADDR'(val);
    bus.i_send = 1'b1;
    model_accept(val, v);
    @(posedge clk);
    #1;
    bus.i_send = hold;
    while (bus.o_rdy !== 1'b1 && busy < 2 * FRAME_LEN) begin
      if (!hold) bus.i_send = 1'($urandom_range(0, 1));
      bus.i_value = ADDR'($urandom);
      if (bus.o_npxl_data === 1'b1) begin
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run > 0) begin
          if (hi_run != T0H && hi_run != T1H) bad_hi++;
          if (nbits < 24 * LEDS) words[nbits / 24][23 - (nbits % 24)] = (hi_run == T1H);
          nbits++;
          last_hi = hi_run;
          hi_run = 0;
        end
        lo_run++;
      end
      busy++;
      @(posedge clk);
      #1;
    end
    bus.i_send = hold;
    chk({tag, "_frame_len"}, busy + 1, FRAME_LEN);
    chk({tag, "_nbits"}, nbits, 24 * LEDS);
    chk({tag, "_bad_high_width"}, bad_hi, 0);
    chk({tag, "_latch_low"}, lo_run, BITC - last_hi + RSTC);
    chk({tag, "_idle_data"}, bus.o_npxl_data, 0);
    for (int k = 0; k < LEDS; k++)
      chk($sformatf("%s_led%0d", tag, k), words[k], exp_word(k, v, m_peak));
  endtask

  task automatic mid_frame_reset();
    int v;
    int cyc = 0, hi_run = 0, nbits = 0;
    bus.i_value = ADDR'(LEDS);
    bus.i_send = 1'b1;
    model_accept(LEDS, v);
    @(posedge clk);
    #1;
    bus.i_send = 1'b0;
    while (!(nbits == 100 && bus.o_npxl_data === 1'b1) && cyc < FRAME_LEN) begin
      if (bus.o_npxl_data === 1'b1) hi_run++;
      else if (hi_run > 0) begin
        nbits++;
        hi_run = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("mid_reached_bit100", nbits, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", bus.o_npxl_data, 0);
    chk("mid_rst_rdy", bus.o_rdy, 1);
    m_peak = 0;
    m_fc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("mid_no_self_start", {bus.o_rdy, bus.o_npxl_data}, 2'b10);
    end
  endtask

  initial begin
    do_reset();
    run_frame(3, 1'b0, "v3");
    run_frame(11, 1'b0, "v11");
    run_frame(17, 1'b0, "v17");
    run_frame(200, 1'b1, "v200_hold");
    run_frame(200, 1'b0, "v200_next");
    run_frame(0, 1'b0, "v0");
    mid_frame_reset();
    run_frame(int'($urandom_range(0, 25)), 1'b0, "rand_a");
    run_frame(int'($urandom_range(0, 25)), 1'b0, "rand_b");
    if (PK) begin
      do_reset();
      run_frame(15, 1'b0, "pk15");
      for (int i = 0; i < 8; i++) run_frame(5, 1'b0, $sformatf("pk5_%0d", i));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
